// File: rtl/vram_write_scheduler.sv
// Text-console VRAM write sequencer: byte FIFO, control-code decode, cursor, full-screen clear.
// Optional VRAM_CLEAR_ON_RESET_EN: leave reset straight into a full clear.
module vram_write_scheduler #(
  parameter int SIZE       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rcv,
  input  logic [7:0]  data_i,
  output logic [6:0]  cursor_x,
  output logic [6:0]  cursor_y,
  output logic        write,
  output logic [12:0] addr_vram,
  output logic [7:0]  character,
  output logic        busy,
  output logic        overflow
);

  localparam int COLS  = 640 / SIZE;
  localparam int ROWS  = 480 / SIZE;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [6:0]  X_MAX    = 7'(COLS - 1);
  localparam logic [6:0]  Y_MAX    = 7'(ROWS - 1);
  localparam logic [12:0] COLS_A   = 13'(COLS);
  localparam logic [12:0] CLR_DONE = 13'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, DECODE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [6:0]      x_q, x_d, y_q, y_d;
  logic            write_q, write_d;
  logic [12:0]     addr_q, addr_d;
  logic [7:0]      char_q, char_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [12:0]     clr_q, clr_d;
  logic            push, pop;

  function automatic logic [12:0] lin(input logic [6:0] col, input logic [6:0] row);
    return 13'(row) * COLS_A + 13'(col);
  endfunction

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cmd_d    = cmd_q;
    x_d      = x_q;
    y_d      = y_q;
    write_d  = 1'b0;
    addr_d   = addr_q;
    char_d   = char_q;
    busy_d   = busy_q;
    clr_d    = clr_q;
    pop      = 1'b0;
    // Fullness is judged before any pop this cycle, so a simultaneous pop never frees a slot.
    push     = rcv && (count_q != CW'(FIFO_DEPTH));
    ovf_d    = rcv && !push;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (cmd_q >= 8'h20 && cmd_q <= 8'h7E) begin
          write_d = 1'b1;
          addr_d  = lin(x_q, y_q);
          char_d  = cmd_q;
          if (x_q == X_MAX) begin
            x_d = '0;
            y_d = (y_q == Y_MAX) ? '0 : y_q + 7'd1;
          end else begin
            x_d = x_q + 7'd1;
          end
        end else begin
          unique case (cmd_q)
            8'h0A, 8'h0D: begin
              x_d = '0;
              y_d = (y_q == Y_MAX) ? '0 : y_q + 7'd1;
            end
            8'h08, 8'h7F: begin
              if (x_q != '0) begin
                x_d     = x_q - 7'd1;
                write_d = 1'b1;
                addr_d  = lin(x_q - 7'd1, y_q);
                char_d  = '0;
              end else if (y_q != '0) begin
                x_d     = X_MAX;
                y_d     = y_q - 7'd1;
                write_d = 1'b1;
                addr_d  = lin(X_MAX, y_q - 7'd1);
                char_d  = '0;
              end
            end
            8'h0C: begin
              state_d = CLEAR;
              busy_d  = 1'b1;
              clr_d   = '0;
            end
            8'h1C: if (x_q != '0)    x_d = x_q - 7'd1;
            8'h1D: if (x_q != X_MAX) x_d = x_q + 7'd1;
            8'h1E: if (y_q != '0)    y_d = y_q - 7'd1;
            8'h1F: if (y_q != Y_MAX) y_d = y_q + 7'd1;
            default: ;
          endcase
        end
      end
      CLEAR: begin
        if (clr_q == CLR_DONE) begin
          busy_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
          state_d = IDLE;
        end else begin
          write_d = 1'b1;
          addr_d  = clr_q;
          char_d  = '0;
          clr_d   = clr_q + 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
`ifdef VRAM_CLEAR_ON_RESET_EN
      state_q <= CLEAR;
      busy_q  <= 1'b1;
`else
      state_q <= IDLE;
      busy_q  <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      char_q   <= '0;
      ovf_q    <= 1'b0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      char_q   <= char_d;
      ovf_q    <= ovf_d;
      clr_q    <= clr_d;
      if (push) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign cursor_x  = x_q;
  assign cursor_y  = y_q;
  assign write     = write_q;
  assign addr_vram = addr_q;
  assign character = char_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: queue-based write/cursor model plus literal pins.
module tb_vram_write_scheduler;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        resetn, rcv;
  logic [7:0]  data_i;
  logic [6:0]  cursor_x, cursor_y;
  logic        write, busy, overflow;
  logic [12:0] addr_vram;
  logic [7:0]  character;

  vram_write_scheduler #(.SIZE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .rcv(rcv), .data_i(data_i),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .write(write),
    .addr_vram(addr_vram), .character(character), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int c;
    int b;
  } wr_t;

  wr_t exp_q[$];
  int  mx, my;
  int  total = 0, bad = 0;
  bit  chk_en = 1'b0;
  int  wr_total = 0, ovf_cnt = 0, run = 0, maxrun = 0;
  int  last_addr = -1, last_char = -1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Screen model: what each accepted byte must do to the cursor and which writes it must cause.
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back('{my * COLS + mx, int'(b), 0});
      mx++;
      if (mx == COLS) begin
        mx = 0;
        my = (my + 1) % ROWS;
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      mx = 0;
      my = (my + 1) % ROWS;
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (mx > 0 || my > 0) begin
        if (mx > 0) mx--;
        else begin
          mx = COLS - 1;
          my--;
        end
        exp_q.push_back('{my * COLS + mx, 0, 0});
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back('{i, 0, 1});
      mx = 0;
      my = 0;
    end else if (b == 8'h1C) begin
      if (mx > 0) mx--;
    end else if (b == 8'h1D) begin
      if (mx < COLS - 1) mx++;
    end else if (b == 8'h1E) begin
      if (my > 0) my--;
    end else if (b == 8'h1F) begin
      if (my < ROWS - 1) my++;
    end
  endfunction

  always @(posedge clk) begin
    wr_t e;
    #1;
    if (chk_en) begin
      if (write) begin
        wr_total++;
        last_addr = int'(addr_vram);
        last_char = int'(character);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr=%0d char=%0h expected no write", addr_vram, character);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(addr_vram), e.a);
          chk("wr_char", int'(character), e.c);
          chk("wr_busy", int'(busy), e.b);
        end
      end
      if (overflow) ovf_cnt++;
      if (write && busy) run++;
      else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      chk("cursor_in_range", int'(cursor_x < 7'(COLS) && cursor_y < 7'(ROWS)), 1);
    end
  end

  task automatic send(input logic [7:0] b, input bit accepted);
    @(negedge clk);
    rcv = 1'b1;
    data_i = b;
    if (accepted) model_byte(b);
    @(negedge clk);
    rcv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_within_budget", int'(n < budget), 1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("busy_rises", int'(busy), 1);
  endtask

  task automatic chk_cursor(input string name, input int x, input int y);
    chk({name, "_x"}, int'(cursor_x), x);
    chk({name, "_y"}, int'(cursor_y), y);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    mx = 0;
    my = 0;
    exp_q.delete();
  endtask

  initial begin
    int wr_before;
    resetn = 1'b0;
    rcv = 1'b0;
    data_i = '0;
    mx = 0;
    my = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", int'(write), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_addr", int'(addr_vram), 0);
    chk("rst_char", int'(character), 0);
    chk_cursor("rst_cursor", 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    // first write appears exactly after the third edge counting the sampling edge
    @(negedge clk);
    rcv = 1'b1;
    data_i = 8'h41;
    model_byte(8'h41);
    @(posedge clk);
    #1 rcv = 1'b0;
    @(posedge clk);
    #1 chk("lat_edge1_write", int'(write), 0);
    @(posedge clk);
    #1 chk("lat_edge2_write", int'(write), 1);
    chk("lat_addr", int'(addr_vram), 0);
    chk("lat_char", int'(character), 8'h41);
    @(posedge clk);
    #1 chk("lat_edge3_write", int'(write), 0);
    chk_cursor("lat_cursor", 1, 0);
    wait_idle(50);

    pulse_reset();
    for (int i = 0; i < 40; i++) send(8'h42, 1'b1);
    wait_idle(100);
    chk("row_last_addr", last_addr, 39);
    chk_cursor("row_cursor", 0, 1);
    chk_cursor("row_model", mx, my);
    send(8'h43, 1'b1);
    wait_idle(50);
    chk("next_row_addr", last_addr, 40);

    send(8'h1C, 1'b1);
    send(8'h7F, 1'b1);
    wait_idle(50);
    chk("bs_wrap_addr", last_addr, 39);
    chk("bs_wrap_char", last_char, 0);
    chk_cursor("bs_wrap_cursor", 39, 0);

    send(8'h0D, 1'b1);
    send(8'h1E, 1'b1);
    send(8'h0A, 1'b1);
    send(8'h07, 1'b1);
    send(8'h1E, 1'b1);
    send(8'h1E, 1'b1);
    wait_idle(50);
    chk_cursor("ctrl_cursor", mx, my);
    for (int i = 0; i < 30; i++) send(8'h1F, 1'b1);
    for (int i = 0; i < 41; i++) send(8'h1D, 1'b1);
    wait_idle(50);
    chk_cursor("corner_cursor", 39, 29);
    send(8'h5A, 1'b1);
    wait_idle(50);
    chk("corner_addr", last_addr, 1199);
    chk("corner_char", last_char, 8'h5A);
    chk_cursor("corner_wrap", 0, 0);
    send(8'h1C, 1'b1);
    wait_idle(50);
    chk_cursor("left_sat", 0, 0);

    // clear with six bytes arriving while the FIFO cannot drain
    ovf_cnt = 0;
    maxrun = 0;
    send(8'h0C, 1'b1);
    wait_busy();
    for (int i = 0; i < 6; i++) send(8'h31, i < 4);
    wait_idle(3000);
    chk("clear_overflows", ovf_cnt, 2);
    chk("clear_run", maxrun, 1200);
    chk("post_clear_addr", last_addr, 3);
    chk("post_clear_char", last_char, 8'h31);
    chk_cursor("post_clear_cursor", 4, 0);

    for (int i = 0; i < 4; i++) send(8'h08, 1'b1);
    wait_idle(50);
    chk("bs_home_addr", last_addr, 0);
    chk_cursor("bs_home_cursor", 0, 0);
    wr_before = wr_total;
    send(8'h7F, 1'b1);
    wait_idle(50);
    chk("bs_origin_nowrite", wr_total, wr_before);
    chk_cursor("bs_origin_cursor", 0, 0);

    // reset mid-clear aborts the clear and empties the FIFO
    chk_en = 1'b0;
    send(8'h0C, 1'b0);
    wait_busy();
    repeat (20) @(posedge clk);
    send(8'h55, 1'b0);
    send(8'h55, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 chk("abort_write", int'(write), 0);
    chk("abort_busy", int'(busy), 0);
    chk_cursor("abort_cursor", 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    mx = 0;
    my = 0;
    exp_q.delete();
    chk_en = 1'b1;
    wr_before = wr_total;
    repeat (8) @(posedge clk);
    #2 chk("abort_fifo_empty", wr_total, wr_before);
    chk("abort_stays_idle", int'(busy), 0);
    send(8'h41, 1'b1);
    wait_idle(50);
    chk("abort_next_addr", last_addr, 0);
    chk_cursor("abort_next_cursor", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
Clocked sequencer that owns the single video-RAM write port of the text console. It buffers received bytes in a small FIFO, decodes control codes, and maintains the cursor. It issues one-cycle character writes and runs a full-screen clear engine that shares the same write port. It sits between the UART receiver strobe and the character VRAM.

Parameters:
SIZE, 16, glyph size in pixels (power of 2, 8..64); COLS = 640/SIZE, ROWS = 480/SIZE are derived localparams.
FIFO_DEPTH, 4, input byte FIFO depth (power of 2, 2..16).

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous reset, active-low
rcv  input  1  one-cycle strobe: data_i valid this cycle
data_i  input  8  received byte
cursor_x  output  7  cursor column, 0..COLS-1
cursor_y  output  7  cursor row, 0..ROWS-1
write  output  1  VRAM write enable, one cycle per write
addr_vram  output  13  VRAM address = row*COLS + col
character  output  8  VRAM write data
busy  output  1  high while in CLEAR state
overflow  output  1  one-cycle pulse when a byte is dropped (FIFO full)

Behaviour:
- Reset (resetn=0 at a clk edge): all outputs 0; FIFO emptied; FSM to IDLE. Applies mid-operation, including mid-clear; the clear is aborted, not resumed.
- FIFO: push when rcv=1 and not full. When full, the byte is dropped and overflow pulses on the next cycle. Full is judged on the pre-pop count, so push and pop in the same cycle while full still drops the byte.
- FSM states: IDLE, DECODE, CLEAR.
- IDLE: if FIFO not empty, pop into cmd register -> DECODE; else stay. write=0.
- DECODE (1 cycle): act on cmd, registering write/addr_vram/character for the next cycle, then -> IDLE (or CLEAR).
  - 0x20..0x7E printable: write cmd at current (x,y), then advance x. If x==COLS-1: x=0, y=y+1. If y==ROWS-1 as well: y=0 (wrap, no scroll).
  - 0x0D CR or 0x0A LF: x=0, y=y+1, with y wrapping ROWS-1->0. No write.
  - 0x08 or 0x7F backspace: if x>0, x=x-1. Else if y>0, x=COLS-1 and y=y-1. At (0,0) nothing happens and no write. Otherwise write 0x00 at the new position.
  - 0x0C form feed: -> CLEAR; no write this cycle.
  - 0x1C/0x1D/0x1E/0x1F: cursor left/right/up/down by one. Saturates at 0 and at COLS-1/ROWS-1. No write.
  - Any other code: ignored, no write.
- Latency: rcv sampled at edge N with FIFO empty and FSM in IDLE. The pop occurs at edge N+1, DECODE at N+2, and write=1 is visible for one cycle after edge N+2. Sustained throughput is one byte per 2 cycles.
- CLEAR:
  - busy=1, character=0, write=1 every cycle; addr_vram steps 0,1,…,COLS*ROWS-1, one per cycle (1200 writes at SIZE=16).
  - After the last address: cursor=(0,0), write=0, busy=0 -> IDLE.
  - rcv during CLEAR is pushed to the FIFO normally and processed afterwards.
- Address arithmetic is done at 13 bits. cursor_x/cursor_y never leave their range.
- write is never asserted in two sources in the same cycle; CLEAR has exclusive ownership of the port.

Optional Feature:
VRAM_CLEAR_ON_RESET_EN:
- Defined: on release of resetn, the FSM enters CLEAR instead of IDLE. busy=1 from the first cycle after reset, and the full clear runs before any byte is processed.
- Undefined: the FSM leaves reset in IDLE and VRAM is not cleared.

Test Plan:
- Reset, rcv with 0x41 -> exactly one write pulse 3 edges later: addr_vram=0, character=0x41; then cursor=(1,0).
- 40 bytes of 0x42 at SIZE=16 -> last write at addr 39; cursor=(0,1); next 0x43 written at addr 40.
- Cursor at (0,1), rcv 0x7F -> write character=0 at addr 39, cursor=(39,0). At (0,0), 0x7F -> no write, cursor unchanged.
- rcv 0x0C, then 6 bytes 0x31 during the clear (FIFO_DEPTH=4):
  - 1200 consecutive writes of 0 at addr 0..1199, with busy high throughout.
  - overflow pulses twice.
  - After the clear, four 0x31 are written at addr 0..3.
- Cursor at (39,29), rcv 0x5A -> write at addr 1199, cursor wraps to (0,0). Then rcv 0x1C -> cursor stays at (0,0).
- resetn low for one cycle mid-clear -> write=0 and busy=0 the next cycle, FIFO empty, cursor=(0,0).
